// File: rtl/mac_unit.sv
// ---------------------------------------------------------------------------
// mac_unit
//
// Signed multiply-accumulate block for the convolution / fully-connected
// datapath. Two pipeline stages: a product register (P, pv) followed by a
// wide accumulator (ACC). An independent output register (Y) snapshots the
// accumulator on request.
//
// Ports
//   clk         rising-edge clock
//   rst         asynchronous, active-low reset
//   clr         synchronous clear of pv and ACC (Y is untouched)
//   en_MAC      accept A, B as a new product term this cycle
//   A, B        signed I_W-bit operands
//   en_MAC_out  load the pre-update ACC into Y this cycle
//   Y           signed 2*I_W+2 bit result register
//
// Configuration
//   MAC_SATURATE_EN  defined: accumulation clamps to the signed range of ACC.
//                    undefined (default): accumulation wraps modulo 2^(2*I_W+2).
// ---------------------------------------------------------------------------
module mac_unit #(
  parameter int I_W = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clr,
  input  logic                      en_MAC,
  input  logic signed [I_W-1:0]     A,
  input  logic signed [I_W-1:0]     B,
  input  logic                      en_MAC_out,
  output logic signed [2*I_W+1:0]   Y
);

  localparam int PW = 2 * I_W;
  localparam int AW = 2 * I_W + 2;

  logic signed [PW-1:0] p_q, p_d;
  logic                 pv_q, pv_d;
  logic signed [AW-1:0] acc_q, acc_d;
  logic signed [AW-1:0] y_q, y_d;

  logic signed [PW-1:0] prod;
  logic signed [AW-1:0] p_ext;
  logic signed [AW-1:0] acc_next;

  // Operands are widened before the multiply so the full-precision product,
  // including (-2^(I_W-1))^2, is exact in PW bits.
  always_comb begin
    prod  = PW'(A) * PW'(B);
    p_ext = {{2{p_q[PW-1]}}, p_q};
  end

`ifdef MAC_SATURATE_EN
  logic signed [AW:0] sum_ext;

  // One extra bit exposes overflow; the two top bits disagree only when the
  // true sum left the AW-bit signed range.
  always_comb begin
    sum_ext  = {acc_q[AW-1], acc_q} + {p_ext[AW-1], p_ext};
    acc_next = sum_ext[AW-1:0];
    if (sum_ext[AW] != sum_ext[AW-1]) begin
      if (sum_ext[AW]) begin
        acc_next = {1'b1, {(AW-1){1'b0}}};
      end else begin
        acc_next = {1'b0, {(AW-1){1'b1}}};
      end
    end
  end
`else
  // Plain two's complement add; carries out of the top bit are dropped.
  always_comb begin
    acc_next = acc_q + p_ext;
  end
`endif

  // Next-state logic. clr kills the in-flight product and zeroes ACC, but a
  // product captured on the same edge survives as the first new term.
  always_comb begin
    p_d   = p_q;
    pv_d  = 1'b0;
    acc_d = acc_q;
    y_d   = y_q;

    if (en_MAC) begin
      p_d  = prod;
      pv_d = 1'b1;
    end

    if (clr) begin
      acc_d = '0;
    end else if (pv_q) begin
      acc_d = acc_next;
    end

    if (en_MAC_out) begin
      y_d = acc_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      p_q   <= '0;
      pv_q  <= 1'b0;
      acc_q <= '0;
      y_q   <= '0;
    end else begin
      p_q   <= p_d;
      pv_q  <= pv_d;
      acc_q <= acc_d;
      y_q   <= y_d;
    end
  end

  assign Y = y_q;

endmodule

// File: tb/tb_mac_unit.sv
// ---------------------------------------------------------------------------
// tb_mac_unit
//
// Self-checking bench for mac_unit (I_W = 32). A behavioural model keeps the
// running sum as a 128-bit integer and applies wrap or clamp to the 66-bit
// result range, following MAC_SATURATE_EN the same way as the design.
// ---------------------------------------------------------------------------
module tb_mac_unit;

  localparam int I_W = 32;
  localparam int AW  = 2 * I_W + 2;

  logic                    clk;
  logic                    rst;
  logic                    clr;
  logic                    en_MAC;
  logic signed [I_W-1:0]   A;
  logic signed [I_W-1:0]   B;
  logic                    en_MAC_out;
  logic signed [AW-1:0]    Y;

  int total;
  int bad;

  // Reference state: the term waiting to be added, the exact running sum and
  // the value last handed to the output.
  bit                    m_pend_valid;
  logic signed [127:0]   m_pend;
  logic signed [127:0]   m_sum;
  logic signed [AW-1:0]  m_y;

  mac_unit #(.I_W(I_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .clr        (clr),
    .en_MAC     (en_MAC),
    .A          (A),
    .B          (B),
    .en_MAC_out (en_MAC_out),
    .Y          (Y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against the expected one and count it.
  task automatic checkOutput(input string tag, input logic signed [AW-1:0] got,
                             input logic signed [AW-1:0] exp);
    total = total + 1;
    if (got !== exp) begin
      bad = bad + 1;
      $display("[TB] FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  function automatic logic signed [127:0] limitSum(input logic signed [127:0] s);
    logic signed [127:0] r;
`ifdef MAC_SATURATE_EN
    logic signed [127:0] hi;
    logic signed [127:0] lo;
    hi = (128'sd1 <<< 65) - 128'sd1;
    lo = -(128'sd1 <<< 65);
    r = s;
    if (s > hi) r = hi;
    if (s < lo) r = lo;
`else
    r = {{62{s[65]}}, s[65:0]};
`endif
    return r;
  endfunction

  task automatic modelReset();
    m_pend_valid = 1'b0;
    m_pend       = '0;
    m_sum        = '0;
    m_y          = '0;
  endtask

  // Drive one cycle of inputs, let one rising edge happen, advance the model
  // and compare Y a little after the edge.
  task automatic applyStimulus(input string tag, input bit en,
                               input logic signed [I_W-1:0] a,
                               input logic signed [I_W-1:0] b,
                               input bit c, input bit o);
    logic signed [127:0] ea;
    logic signed [127:0] eb;
    en_MAC     = en;
    A          = a;
    B          = b;
    clr        = c;
    en_MAC_out = o;
    @(posedge clk);
    if (rst) begin
      if (o) m_y = m_sum[AW-1:0];
      if (c) m_sum = '0;
      else if (m_pend_valid) m_sum = limitSum(m_sum + m_pend);
      m_pend_valid = en;
      if (en) begin
        ea = 128'(a);
        eb = 128'(b);
        m_pend = ea * eb;
      end
    end
    #1;
    checkOutput(tag, Y, m_y);
  endtask

  logic signed [I_W-1:0] ra;
  logic signed [I_W-1:0] rb;

  initial begin
    total = 0;
    bad   = 0;
    modelReset();
    rst = 1'b0;
    clr = 1'b0;
    en_MAC = 1'b0;
    en_MAC_out = 1'b0;
    A = '0;
    B = '0;

    // Held in reset with live operands: nothing may move.
    for (int i = 0; i < 3; i++) begin
      applyStimulus("reset_hold", 1'b1, $urandom, $urandom, 1'b0, 1'b1);
    end
    #2 rst = 1'b1;

    // Two-term directed sequence: 12 appears two edges after the first
    // sample, 12 + (-10) = 2 one edge later.
    applyStimulus("dir_e0", 1'b1, 3, 4, 1'b0, 1'b1);
    checkOutput("dir_e0_zero", Y, 0);
    applyStimulus("dir_e1", 1'b1, -5, 2, 1'b0, 1'b1);
    applyStimulus("dir_e2", 1'b0, 0, 0, 1'b0, 1'b1);
    checkOutput("dir_y12", Y, 12);
    applyStimulus("dir_e3", 1'b0, 0, 0, 1'b0, 1'b1);
    checkOutput("dir_y2", Y, 2);

    // Random small operands in -19..19, checked every cycle.
    for (int i = 0; i < 10; i++) begin
      ra = I_W'(int'($urandom_range(38)) - 19);
      rb = I_W'(int'($urandom_range(38)) - 19);
      applyStimulus("rand_stream", 1'b1, ra, rb, 1'b0, 1'b1);
    end
    applyStimulus("rand_drain0", 1'b0, 0, 0, 1'b0, 1'b1);
    applyStimulus("rand_drain1", 1'b0, 0, 0, 1'b0, 1'b1);

    // Clear with a same-edge product: the old sum and in-flight term vanish,
    // the new product becomes the only term. Y stays frozen meanwhile.
    applyStimulus("clr_pre", 1'b0, 0, 0, 1'b1, 1'b1);
    applyStimulus("clr_pre2", 1'b0, 0, 0, 1'b0, 1'b1);
    checkOutput("clr_pre_zero", Y, 0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus("clr_acc", 1'b1, 7, 7, 1'b0, 1'b0);
    end
    applyStimulus("clr_edge", 1'b1, 2, 3, 1'b1, 1'b0);
    checkOutput("clr_y_frozen", Y, 0);
    applyStimulus("clr_drain", 1'b0, 0, 0, 1'b0, 1'b0);
    applyStimulus("clr_load", 1'b0, 0, 0, 1'b0, 1'b1);
    checkOutput("clr_y6", Y, 6);

    // Operands toggling with en_MAC low leave the sum alone.
    for (int i = 0; i < 4; i++) begin
      applyStimulus("gate_mac", 1'b0, $urandom, $urandom, 1'b0, 1'b1);
    end
    checkOutput("gate_y6", Y, 6);

    // Y frozen while the sum grows, then loaded on request.
    for (int i = 0; i < 4; i++) begin
      ra = I_W'(int'($urandom_range(1000)) + 1);
      applyStimulus("gate_out", 1'b1, ra, 5, 1'b0, 1'b0);
    end
    applyStimulus("gate_out_drain", 1'b0, 0, 0, 1'b0, 1'b0);
    checkOutput("gate_out_frozen", Y, 6);
    applyStimulus("gate_out_load", 1'b0, 0, 0, 1'b0, 1'b1);

    // Most negative operands: each term is +2^62; twelve terms overflow the
    // 66-bit range (wrap or clamp depending on the build).
    applyStimulus("ext_clr", 1'b0, 0, 0, 1'b1, 1'b1);
    for (int i = 0; i < 12; i++) begin
      applyStimulus("ext_term", 1'b1, 32'sh8000_0000, 32'sh8000_0000, 1'b0, 1'b1);
    end
    applyStimulus("ext_drain0", 1'b0, 0, 0, 1'b0, 1'b1);
    applyStimulus("ext_drain1", 1'b0, 0, 0, 1'b0, 1'b1);
`ifdef MAC_SATURATE_EN
    checkOutput("ext_clamp", Y, {1'b0, {(AW-1){1'b1}}});
`else
    checkOutput("ext_wrap", Y, -(66'sd1 <<< 64));
`endif

    // Refill with a known positive sum, then reset between edges.
    applyStimulus("async_fill", 1'b1, 100, 3, 1'b0, 1'b1);
    applyStimulus("async_fill1", 1'b1, 1, 1, 1'b0, 1'b1);
    #3 rst = 1'b0;
    #1;
    modelReset();
    checkOutput("async_y_zero", Y, 0);
    #2 rst = 1'b1;
    applyStimulus("restart_e0", 1'b1, 3, 4, 1'b0, 1'b1);
    applyStimulus("restart_e1", 1'b0, 0, 0, 1'b0, 1'b1);
    checkOutput("restart_zero", Y, 0);
    applyStimulus("restart_e2", 1'b0, 0, 0, 1'b0, 1'b1);
    checkOutput("restart_y12", Y, 12);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
